// File: rtl/rng_cmd_evaluator_pkg.sv
// Shared state encoding and sizing helpers for the
// random-value command evaluator and its remainder unit.
package rng_cmd_evaluator_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      REDUCE  = 3'd2,
      CHECK   = 3'd3,
      PRESENT = 3'd4
   } state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

   // Largest multiple of n not exceeding 2^w; values at or above it are rejected.
   function automatic int calc_limit(input int w, input int n);
      return ((1 << w) / n) * n;
   endfunction

endpackage

// File: rtl/rng_mod_reduce.sv
// Serial restoring remainder: one dividend bit per cycle,
// WIDTH cycles after start; done flags the final step.
module rng_mod_reduce
   import rng_cmd_evaluator_pkg::*;
#(
   parameter  int WIDTH    = 8,
   parameter  int NUM_CMDS = 4,
   localparam int CW       = clog2(NUM_CMDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   output logic             done,
   output logic [CW-1:0]    remainder
);

   localparam logic [CW:0] DIV = (CW+1)'(NUM_CMDS);

   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    rem_q, rem_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [CW:0]      trial;

   always_comb begin
      shift_d = shift_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      trial   = {rem_q, shift_q[WIDTH-1]};
      if (start) begin
         shift_d = dividend;
         rem_d   = '0;
         cnt_d   = 5'(WIDTH);
      end else if (cnt_q != 5'd0) begin
         shift_d = shift_q << 1;
         rem_d   = (trial >= DIV) ? CW'(trial - DIV) : trial[CW-1:0];
         cnt_d   = cnt_q - 5'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
      end
   end

   assign done      = (cnt_q == 5'd1);
   assign remainder = rem_q;

endmodule

// File: rtl/rng_cmd_evaluator.sv
// Maps raw LFSR values onto unbiased game commands with
// rejection sampling, a repeat limiter and a valid/ack output.
module rng_cmd_evaluator
   import rng_cmd_evaluator_pkg::*;
#(
   parameter  int WIDTH      = 8,
   parameter  int NUM_CMDS   = 4,
   parameter  int MAX_REPEAT = 2,
   parameter  int MAX_REJECT = 15,
   localparam int CW         = clog2(NUM_CMDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] rng_value,
   input  logic             rng_valid,
   output logic             rng_ready,
   input  logic             req,
   output logic [CW-1:0]    cmd_out,
   output logic             cmd_valid,
   input  logic             cmd_ack,
   output logic             busy,
   output logic             fallback,
   output logic [7:0]       reject_count
);

   // One extra bit so LIMIT = 2^WIDTH is representable.
   localparam logic [WIDTH:0] LIMIT    = (WIDTH+1)'(calc_limit(WIDTH, NUM_CMDS));
   localparam logic [7:0]     REJ_LAST = 8'(MAX_REJECT - 1);
   localparam logic [7:0]     REP_MAX  = 8'(MAX_REPEAT);
   localparam logic [CW-1:0]  CMD_TOP  = CW'(NUM_CMDS - 1);

   state_e        state_q, state_d;
   logic [7:0]    draw_rej_q, draw_rej_d;
   logic [7:0]    rej_cnt_q, rej_cnt_d;
   logic [7:0]    rep_q, rep_d;
   logic          fb_q, fb_d;
   logic          have_last_q, have_last_d;
   logic          cmd_valid_q, cmd_valid_d;
   logic [CW-1:0] fb_cand_q, fb_cand_d;
   logic [CW-1:0] last_q, last_d;
   logic [CW-1:0] cmd_q, cmd_d;

   logic [WIDTH:0] val_ext;
   logic [CW-1:0]  fb_pick, red_rem, base, pick;
   logic           in_range, red_start, red_done, accepted;

   assign val_ext   = {1'b0, rng_value};
   assign in_range  = val_ext < LIMIT;
   assign fb_pick   = CW'(val_ext - LIMIT);
   assign red_start = (state_q == FETCH) && rng_valid && in_range;
   assign accepted  = cmd_valid_q && cmd_ack;

   rng_mod_reduce #(
      .WIDTH    (WIDTH),
      .NUM_CMDS (NUM_CMDS)
   ) u_reduce (
      .clk       (clk),
      .rst       (rst),
      .start     (red_start),
      .dividend  (rng_value),
      .done      (red_done),
      .remainder (red_rem)
   );

   always_comb begin
      state_d     = state_q;
      draw_rej_d  = draw_rej_q;
      rej_cnt_d   = rej_cnt_q;
      rep_d       = rep_q;
      fb_d        = fb_q;
      have_last_d = have_last_q;
      cmd_valid_d = 1'b0;
      fb_cand_d   = fb_cand_q;
      last_d      = last_q;
      cmd_d       = cmd_q;

      base = fb_q ? fb_cand_q : red_rem;
      pick = base;
      if (MAX_REPEAT != 0 && have_last_q && base == last_q && rep_q >= REP_MAX)
         pick = (base == CMD_TOP) ? '0 : base + CW'(1);

      unique case (state_q)
         IDLE: begin
            if (req) begin
               draw_rej_d = '0;
               fb_d       = 1'b0;
               state_d    = FETCH;
            end
         end
         FETCH: begin
            if (rng_valid) begin
               if (in_range) begin
                  state_d = REDUCE;
               end else begin
                  if (rej_cnt_q != 8'hFF) rej_cnt_d = rej_cnt_q + 8'd1;
                  if (draw_rej_q == REJ_LAST) begin
                     fb_cand_d = fb_pick;
                     fb_d      = 1'b1;
                     state_d   = CHECK;
                  end else begin
                     draw_rej_d = draw_rej_q + 8'd1;
                  end
               end
            end
         end
         REDUCE: begin
            if (red_done) state_d = CHECK;
         end
         CHECK: begin
            if (have_last_q && pick == last_q)
               rep_d = (rep_q == 8'hFF) ? rep_q : rep_q + 8'd1;
            else
               rep_d = 8'd1;
            last_d      = pick;
            have_last_d = 1'b1;
            cmd_d       = pick;
            state_d     = PRESENT;
         end
         PRESENT: begin
            cmd_valid_d = !accepted;
            if (accepted) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         draw_rej_q  <= '0;
         rej_cnt_q   <= '0;
         rep_q       <= '0;
         fb_q        <= 1'b0;
         have_last_q <= 1'b0;
         cmd_valid_q <= 1'b0;
         fb_cand_q   <= '0;
         last_q      <= '0;
         cmd_q       <= '0;
      end else begin
         state_q     <= state_d;
         draw_rej_q  <= draw_rej_d;
         rej_cnt_q   <= rej_cnt_d;
         rep_q       <= rep_d;
         fb_q        <= fb_d;
         have_last_q <= have_last_d;
         cmd_valid_q <= cmd_valid_d;
         fb_cand_q   <= fb_cand_d;
         last_q      <= last_d;
         cmd_q       <= cmd_d;
      end
   end

   assign rng_ready    = (state_q == FETCH);
   assign busy         = (state_q != IDLE);
   assign cmd_out      = cmd_q;
   assign cmd_valid    = cmd_valid_q;
   assign fallback     = fb_q;
   assign reject_count = rej_cnt_q;

endmodule

// File: tb/tb_rng_cmd_evaluator.sv
// Scoreboard bench for rng_cmd_evaluator: WIDTH=8, NUM_CMDS=3,
// MAX_REPEAT=2, MAX_REJECT=15 (LIMIT=255).
module tb_rng_cmd_evaluator;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rng_value = '0;
   logic       rng_valid = 1'b1;
   logic       rng_ready;
   logic       req = 1'b0;
   logic [1:0] cmd_out;
   logic       cmd_valid;
   logic       cmd_ack = 1'b0;
   logic       busy;
   logic       fallback;
   logic [7:0] reject_count;

   rng_cmd_evaluator #(
      .WIDTH      (8),
      .NUM_CMDS   (3),
      .MAX_REPEAT (2),
      .MAX_REJECT (15)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rng_value    (rng_value),
      .rng_valid    (rng_valid),
      .rng_ready    (rng_ready),
      .req          (req),
      .cmd_out      (cmd_out),
      .cmd_valid    (cmd_valid),
      .cmd_ack      (cmd_ack),
      .busy         (busy),
      .fallback     (fallback),
      .reject_count (reject_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cmd;
      int fb;
      int rc;
      int lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   fails = 0;
   int   cyc = 0;
   int   req_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expectation per rising cmd_valid, then
   // checks cmd_out stays put while it is held.
   logic prev_v = 1'b0;
   int   held = 0;
   always @(negedge clk) begin : mon
      exp_t e;
      if (cmd_valid && !prev_v) begin
         if (sb.size() == 0) begin
            chk("unexpected_cmd", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("cmd_out", int'(cmd_out), e.cmd);
            chk("fallback", int'(fallback), e.fb);
            chk("reject_count", int'(reject_count), e.rc);
            chk("latency", cyc - req_cyc, e.lat);
         end
         held = int'(cmd_out);
      end else if (cmd_valid) begin
         chk("cmd_stable", int'(cmd_out), held);
      end
      prev_v = cmd_valid;
   end

   task automatic wait_ack(input int hold, input bit poke);
      int n;
      n = 0;
      while (!cmd_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_valid) begin
         chk("cmd_valid_timeout", 0, 1);
         return;
      end
      repeat (hold) begin
         if (poke) begin
            req       = 1'b1;
            rng_valid = ~rng_valid;
            rng_value = 8'hFF;
         end
         @(negedge clk);
         req = 1'b0;
      end
      rng_valid = 1'b1;
      cmd_ack = 1'b1;
      @(negedge clk);
      cmd_ack = 1'b0;
      chk("valid_after_ack", int'(cmd_valid), 0);
      chk("busy_after_ack", int'(busy), 0);
   endtask

   // Called on a negedge in IDLE; each value is driven while FETCH is ready.
   task automatic draw(input int vals[$], input int hold, input bit poke,
                       input int ecmd, input int efb, input int erc,
                       input int elat);
      exp_t e;
      e = '{ecmd, efb, erc, elat};
      sb.push_back(e);
      rng_value = 8'(vals[0]);
      req       = 1'b1;
      req_cyc   = cyc + 1;
      @(negedge clk);
      req = 1'b0;
      foreach (vals[i]) begin
         rng_value = 8'(vals[i]);
         chk("rng_ready", int'(rng_ready), 1);
         @(negedge clk);
      end
      wait_ack(hold, poke);
   endtask

   initial begin
      int v[$];
      #1;
      chk("rst_cmd_valid", int'(cmd_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_rng_ready", int'(rng_ready), 0);
      chk("rst_fallback", int'(fallback), 0);
      chk("rst_reject_count", int'(reject_count), 0);
      chk("rst_cmd_out", int'(cmd_out), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      v = '{200};
      draw(v, 0, 1'b0, 2, 0, 0, 11);
      v = '{255, 10};
      draw(v, 0, 1'b0, 1, 0, 1, 12);
      v.delete();
      for (int i = 0; i < 15; i++) v.push_back(255);
      draw(v, 0, 1'b0, 0, 1, 16, 17);

      v = '{2};
      draw(v, 0, 1'b0, 2, 0, 16, 11);
      v = '{5};
      draw(v, 0, 1'b0, 2, 0, 16, 11);
      v = '{8};
      draw(v, 0, 1'b0, 0, 0, 16, 11);
      draw(v, 0, 1'b0, 2, 0, 16, 11);

      v = '{4};
      draw(v, 6, 1'b1, 1, 0, 16, 11);
      repeat (4) @(negedge clk);
      chk("busy_no_extra_draw", int'(busy), 0);

      rng_value = 8'd100;
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (4) @(negedge clk);
      chk("busy_in_reduce", int'(busy), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_cmd_valid", int'(cmd_valid), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_rng_ready", int'(rng_ready), 0);
      chk("mid_rst_reject_count", int'(reject_count), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      v = '{7};
      draw(v, 0, 1'b0, 1, 0, 0, 11);

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

endmodule
